// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: N-digit time-multiplexed 7-segment driver.
// Scans packed hex digits onto a common-anode display with a blank gap between
// slots, optional leading-zero blanking and frame-coherent input capture.
module seg7_mux_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned BLANK_CYCLES   = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  localparam int unsigned IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              display,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      LAST_PRE = PRE_W'(REFRESH_DIV - 1);
  localparam logic                  SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_INV   = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF  = SEG_INV ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_INV ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  load_pending_q, load_pending_d;
  logic [6:0]            display_q, display_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  logic                  tick_c;
  logic                  capture_c;
  logic                  in_blank_c;
  logic [3:0]            nib_c;
  logic                  dp_sel_c;
  logic                  lz_blank_c;
  logic                  zero_run_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] onehot_c;

  // Hex nibble to active-high abcdefg segment pattern (a = bit 6).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Anti-ghosting gap: anodes stay off for the first BLANK_CYCLES of a slot.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_c = 1'b0;
    end else begin : g_blank
      assign in_blank_c = (prescaler_q < PRE_W'(BLANK_CYCLES));
    end
  endgenerate

  // Slot prescaler and digit scan counter; both hold while disabled.
  always_comb begin
    prescaler_d = prescaler_q;
    digit_idx_d = digit_idx_q;
    tick_c      = enable && (prescaler_q == LAST_PRE);
    if (enable) begin
      prescaler_d = (prescaler_q == LAST_PRE) ? '0 : prescaler_q + PRE_W'(1);
    end
    if (tick_c) begin
      digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  // Shadow capture on the first enabled edge after reset, then at each frame end.
  always_comb begin
    capture_c      = enable && (load_pending_q || (tick_c && (digit_idx_q == LAST_IDX)));
    shadow_val_d   = capture_c ? value : shadow_val_q;
    shadow_dp_d    = capture_c ? dp_in : shadow_dp_q;
    load_pending_d = load_pending_q && !enable;
  end

  // Select the current digit's nibble/dp and evaluate leading-zero blanking.
  always_comb begin
    nib_c      = 4'h0;
    dp_sel_c   = 1'b0;
    lz_blank_c = 1'b0;
    zero_run_c = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (shadow_val_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == digit_idx_q) begin
        nib_c      = shadow_val_q[4*i +: 4];
        dp_sel_c   = shadow_dp_q[i];
        lz_blank_c = blank_lz && zero_run_c && (i != 0);
      end
    end
  end

  // Next output register values with pin polarity applied last.
  always_comb begin
    anode_d   = AN_OFF;
    onehot_c  = NUM_DIGITS'(1) << digit_idx_q;
    seg_c     = lz_blank_c ? 7'h00 : hex_to_seg(nib_c);
    display_d = SEG_INV ? ~seg_c : seg_c;
    dp_d      = SEG_INV ? ~dp_sel_c : dp_sel_c;
    if (enable && !in_blank_c) begin
      anode_d = AN_INV ? ~onehot_c : onehot_c;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      digit_idx_q    <= '0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      load_pending_q <= 1'b1;
      display_q      <= SEG_OFF;
      dp_q           <= DP_OFF;
      anode_q        <= AN_OFF;
    end else begin
      prescaler_q    <= prescaler_d;
      digit_idx_q    <= digit_idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      load_pending_q <= load_pending_d;
      display_q      <= display_d;
      dp_q           <= dp_d;
      anode_q        <= anode_d;
    end
  end

  assign display   = display_q;
  assign dp        = dp_q;
  assign anode     = anode_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: 4-digit scan, active-low segment variant,
// and a single-digit instance for the full hex decode sweep.
module tb_seg7_mux_driver;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  display;
  logic        dp;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;

  logic [6:0]  display_p;
  logic        dp_p;
  logic [3:0]  anode_p;
  logic [1:0]  digit_idx_p;

  logic        en1;
  logic [3:0]  value1;
  logic [0:0]  dp_in1;
  logic [6:0]  display1;
  logic        dp1;
  logic [0:0]  anode1;
  logic [0:0]  digit_idx1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .display(display), .dp(dp), .anode(anode), .digit_idx(digit_idx)
  );

  seg7_mux_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut_pol (
    .clk(clk), .reset(reset), .enable(enable), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .display(display_p), .dp(dp_p), .anode(anode_p), .digit_idx(digit_idx_p)
  );

  seg7_mux_driver #(
    .NUM_DIGITS(1), .REFRESH_DIV(2), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .value(value1), .dp_in(dp_in1),
    .blank_lz(1'b0), .display(display1), .dp(dp1), .anode(anode1), .digit_idx(digit_idx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_anode(input logic [3:0] a, input string tag);
    int n = 0;
    while (anode !== a && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, 32'(anode), 32'(a));
  endtask

  task automatic wait_idx(input logic [1:0] idx, input string tag);
    int n = 0;
    while (digit_idx !== idx && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, 32'(digit_idx), 32'(idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    value    = 16'h0000;
    dp_in    = 4'b0000;
    blank_lz = 1'b0;
    en1      = 1'b0;
    value1   = 4'h0;
    dp_in1   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_anode", 32'(anode), 32'(4'b1111));
    check("rst_display", 32'(display), 32'(7'b0000000));
    check("rst_dp", 32'(dp), 32'(1'b0));
    check("rst_idx", 32'(digit_idx), 32'(2'd0));
    check("rst_pol_display", 32'(display_p), 32'(7'b1111111));
    check("rst_pol_dp", 32'(dp_p), 32'(1'b1));

    // Reset release and first capture
    value  = 16'h1234;
    enable = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check("first_blank_anode", 32'(anode), 32'(4'b1111));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d0_anode", 32'(anode), 32'(4'b1110));
      check("d0_display", 32'(display), 32'(7'b0110011));
    end
    @(negedge clk);
    check("d1_gap_anode", 32'(anode), 32'(4'b1111));
    check("d1_gap_idx", 32'(digit_idx), 32'(2'd1));
    @(negedge clk);
    check("d1_anode", 32'(anode), 32'(4'b1101));
    check("d1_display", 32'(display), 32'(7'b1111001));
    check("d1_dp", 32'(dp), 32'(1'b0));

    // Frame coherence: change value mid-frame at digit 1
    value = 16'hABCD;
    wait_anode(4'b1011, "fc_d2");
    check("fc_d2_display", 32'(display), 32'(7'b1101101));
    wait_anode(4'b0111, "fc_d3");
    check("fc_d3_display", 32'(display), 32'(7'b0110000));
    wait_anode(4'b1110, "fc_new_d0");
    check("fc_new_d0_display", 32'(display), 32'(7'b0111101));
    wait_anode(4'b1101, "fc_new_d1");
    check("fc_new_d1_display", 32'(display), 32'(7'b1001110));

    // Leading-zero blanking with a dp on the blanked top digit
    value    = 16'h0050;
    blank_lz = 1'b1;
    dp_in    = 4'b1000;
    wait_idx(2'd3, "lz_sync");
    wait_anode(4'b1110, "lz_d0");
    check("lz_d0_display", 32'(display), 32'(7'b1111110));
    check("lz_d0_dp", 32'(dp), 32'(1'b0));
    wait_anode(4'b1101, "lz_d1");
    check("lz_d1_display", 32'(display), 32'(7'b1011011));
    wait_anode(4'b1011, "lz_d2");
    check("lz_d2_display", 32'(display), 32'(7'b0000000));
    check("lz_d2_dp", 32'(dp), 32'(1'b0));
    wait_anode(4'b0111, "lz_d3");
    check("lz_d3_display", 32'(display), 32'(7'b0000000));
    check("lz_d3_dp", 32'(dp), 32'(1'b1));
    check("pol_blank_display", 32'(display_p), 32'(7'b1111111));
    check("pol_dp_on", 32'(dp_p), 32'(1'b0));

    // All-zero value: digit 0 still shows "0", digit 1 blanked
    value = 16'h0000;
    dp_in = 4'b0000;
    wait_idx(2'd3, "zero_sync");
    wait_anode(4'b1110, "zero_d0");
    check("zero_d0_display", 32'(display), 32'(7'b1111110));
    wait_anode(4'b1101, "zero_d1");
    check("zero_d1_display", 32'(display), 32'(7'b0000000));

    // Drop enable at digit 2 with prescaler = 2
    wait_anode(4'b1011, "en_d2");
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("dis_anode", 32'(anode), 32'(4'b1111));
      check("dis_idx", 32'(digit_idx), 32'(2'd2));
    end
    enable = 1'b1;
    @(negedge clk);
    check("reen_anode", 32'(anode), 32'(4'b1011));
    check("reen_idx", 32'(digit_idx), 32'(2'd2));
    @(negedge clk);
    check("reen_last_anode", 32'(anode), 32'(4'b1011));
    check("reen_wrap_idx", 32'(digit_idx), 32'(2'd3));
    @(negedge clk);
    check("reen_gap_anode", 32'(anode), 32'(4'b1111));

    // Asynchronous reset in the middle of a cycle
    wait_anode(4'b1110, "ar_d0");
    check("ar_pre_display", 32'(display), 32'(7'b1111110));
    #2;
    reset = 1'b1;
    #1;
    check("ar_anode", 32'(anode), 32'(4'b1111));
    check("ar_display", 32'(display), 32'(7'b0000000));
    check("ar_idx", 32'(digit_idx), 32'(2'd0));
    check("ar_pol_display", 32'(display_p), 32'(7'b1111111));
    value    = 16'h1234;
    blank_lz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_first_anode", 32'(anode), 32'(4'b1111));
    @(negedge clk);
    check("ar_d0_anode", 32'(anode), 32'(4'b1110));
    check("ar_d0_display", 32'(display), 32'(7'b0110011));

    // Segment polarity on an "8"
    value = 16'h8888;
    wait_idx(2'd3, "p8_sync");
    wait_anode(4'b1110, "p8_d0");
    check("p8_display", 32'(display), 32'(7'b1111111));
    check("p8_pol_display", 32'(display_p), 32'(7'b0000000));

    // Single-digit full hex sweep
    en1 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      value1 = 4'(v);
      repeat (4) @(negedge clk);
      check($sformatf("hex_%0h_display", v), 32'(display1), 32'(SEG_TAB[v]));
      check("hex_anode", 32'(anode1), 32'(1'b0));
      check("hex_idx", 32'(digit_idx1), 32'(1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
